// File: rtl/spi_rom_burst_reader_pkg.sv
// Shared types and constants for the SPI flash burst reader.
package spi_rom_burst_reader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_ADDR  = 3'd2,
      ST_DUMMY = 3'd3,
      ST_DATA  = 3'd4,
      ST_GAP   = 3'd5
   } state_t;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_QREAD = 8'h6B;

   // Next receive byte: one bit from io1 in single mode, one nibble from io[3:0] in quad mode.
   function automatic logic [7:0] rx_shift(input logic [7:0] rx, input logic quad,
                                           input logic [3:0] din);
      logic [7:0] nxt;
      if (quad) begin
         nxt = {rx[3:0], din};
      end else begin
         nxt = {rx[6:0], din[1]};
      end
      return nxt;
   endfunction

endpackage

// File: rtl/spi_rom_burst_reader_if.sv
// Request / byte-stream bundle between the line fetcher (master) and the reader (slave).
interface spi_rom_burst_reader_if #(
   parameter int ADDR_W = 24,
   parameter int LEN_W  = 10
) ();
   logic              quad;
   logic              start;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  len;
   logic              abort;
   logic              busy;
   logic              done;
   logic [7:0]        out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (output quad, start, addr, len, abort, out_ready,
                   input  busy, done, out_data, out_valid);
   modport slave  (input  quad, start, addr, len, abort, out_ready,
                   output busy, done, out_data, out_valid);
endinterface

// File: rtl/spi_rom_burst_reader_sclk_gen.sv
// SCLK divider: CLK_DIV clk cycles per half-period, idle low. A stall only blocks the
// next rising edge, so SCLK parks low. 'fall' marks the clk edge that ends a high phase.
module spi_rom_burst_reader_sclk_gen #(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic stall,
   output logic sclk,
   output logic fall
);
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_r;
   logic             sclk_r;

   assign sclk = sclk_r;
   assign fall = run && sclk_r && (cnt_r == CNT_LAST);

   // Half-period counter and SCLK toggle, rises held off while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r  <= '0;
         sclk_r <= 1'b0;
      end else if (!run) begin
         cnt_r  <= '0;
         sclk_r <= 1'b0;
      end else if (cnt_r == CNT_LAST) begin
         if (sclk_r) begin
            sclk_r <= 1'b0;
            cnt_r  <= '0;
         end else if (!stall) begin
            sclk_r <= 1'b1;
            cnt_r  <= '0;
         end
      end else begin
         cnt_r <= cnt_r + 1'b1;
      end
   end
endmodule

// File: rtl/spi_rom_burst_reader.sv
// SPI flash burst reader: READ (0x03) or quad output fast read (0x6B), streams len+1 bytes
// out as valid/ready with SCLK back-pressure; abortable at any point of a burst.
module spi_rom_burst_reader
   import spi_rom_burst_reader_pkg::*;
#(
   parameter int ADDR_W  = 24,
   parameter int LEN_W   = 10,
   parameter int CLK_DIV = 1,
   parameter int DUMMY   = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   spi_rom_burst_reader_if.slave  bus,
   output logic                   spi_cs_n,
   output logic                   spi_sclk,
   output logic                   spi_out0,
   output logic                   spi_oe0,
   input  logic [3:0]             spi_in
);
   localparam int TX_W  = 8 + ADDR_W;
   localparam int GAP_W = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(2 * CLK_DIV - 1);
   localparam logic [7:0]       ADDR_LAST  = 8'(ADDR_W - 1);
   localparam logic [7:0]       DUMMY_LAST = 8'(DUMMY - 1);

   state_t            state_r;
   logic              quad_r;
   logic [LEN_W-1:0]  len_r;
   logic [TX_W-1:0]   tx_r;
   logic [7:0]        rx_r;
   logic [7:0]        bits_r;
   logic [LEN_W:0]    byte_cnt_r;
   logic [GAP_W-1:0]  gap_cnt_r;
   logic              pend_r;
   logic              busy_r;
   logic              done_r;
   logic [7:0]        out_data_r;
   logic              out_valid_r;
   logic              cs_n_r;
   logic              out0_r;
   logic              oe0_r;

   logic              run_s;
   logic              fall_s;
   logic [7:0]        rx_next_s;
   logic              byte_end_s;
   logic              out_free_s;
   logic [7:0]        cmd_s;

   spi_rom_burst_reader_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run_s),
      .stall (pend_r),
      .sclk  (spi_sclk),
      .fall  (fall_s)
   );

   // Run the clock in the active transfer states; the next byte value; output-reg availability
   always_comb begin
      run_s = 1'b0;
      case (state_r)
         ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: run_s = !bus.abort;
         default:                            run_s = 1'b0;
      endcase
      rx_next_s  = rx_shift(rx_r, quad_r, spi_in);
      byte_end_s = quad_r ? (bits_r == 8'd1) : (bits_r == 8'd7);
      out_free_s = !out_valid_r || bus.out_ready;
      cmd_s      = bus.quad ? CMD_QREAD : CMD_READ;
   end

   // Burst sequencer with command/address shifter, data shifter and output byte register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         quad_r      <= 1'b0;
         len_r       <= '0;
         tx_r        <= '0;
         rx_r        <= 8'h00;
         bits_r      <= 8'h00;
         byte_cnt_r  <= '0;
         gap_cnt_r   <= '0;
         pend_r      <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         out_data_r  <= 8'h00;
         out_valid_r <= 1'b0;
         cs_n_r      <= 1'b1;
         out0_r      <= 1'b0;
         oe0_r       <= 1'b1;
      end else begin
         done_r <= 1'b0;
         if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
         // A byte parked in the shift register moves out as soon as the output frees up
         if (pend_r && out_free_s) begin
            out_data_r  <= rx_r;
            out_valid_r <= 1'b1;
            pend_r      <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  quad_r     <= bus.quad;
                  len_r      <= bus.len;
                  tx_r       <= {cmd_s, bus.addr};
                  out0_r     <= cmd_s[7];
                  cs_n_r     <= 1'b0;
                  busy_r     <= 1'b1;
                  bits_r     <= 8'h00;
                  byte_cnt_r <= '0;
                  rx_r       <= 8'h00;
                  state_r    <= ST_CMD;
               end
            end
            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
               if (bus.abort) begin
                  state_r   <= ST_GAP;
                  cs_n_r    <= 1'b1;
                  oe0_r     <= 1'b1;
                  out0_r    <= 1'b0;
                  pend_r    <= 1'b0;
                  gap_cnt_r <= '0;
               end else if (fall_s) begin
                  case (state_r)
                     ST_CMD: begin
                        tx_r   <= {tx_r[TX_W-2:0], 1'b0};
                        out0_r <= tx_r[TX_W-2];
                        if (bits_r == 8'd7) begin
                           bits_r  <= 8'h00;
                           state_r <= ST_ADDR;
                        end else begin
                           bits_r <= bits_r + 8'd1;
                        end
                     end
                     ST_ADDR: begin
                        tx_r   <= {tx_r[TX_W-2:0], 1'b0};
                        out0_r <= tx_r[TX_W-2];
                        if (bits_r == ADDR_LAST) begin
                           bits_r  <= 8'h00;
                           out0_r  <= 1'b0;
                           oe0_r   <= !quad_r;
                           state_r <= (quad_r && (DUMMY > 0)) ? ST_DUMMY : ST_DATA;
                        end else begin
                           bits_r <= bits_r + 8'd1;
                        end
                     end
                     ST_DUMMY: begin
                        if (bits_r == DUMMY_LAST) begin
                           bits_r  <= 8'h00;
                           state_r <= ST_DATA;
                        end else begin
                           bits_r <= bits_r + 8'd1;
                        end
                     end
                     default: begin
                        rx_r <= rx_next_s;
                        if (byte_end_s) begin
                           bits_r     <= 8'h00;
                           byte_cnt_r <= byte_cnt_r + 1'b1;
                           if (out_free_s) begin
                              out_data_r  <= rx_next_s;
                              out_valid_r <= 1'b1;
                           end else begin
                              pend_r <= 1'b1;
                           end
                           if (byte_cnt_r == {1'b0, len_r}) begin
                              state_r   <= ST_GAP;
                              cs_n_r    <= 1'b1;
                              oe0_r     <= 1'b1;
                              gap_cnt_r <= '0;
                           end
                        end else begin
                           bits_r <= bits_r + 8'd1;
                        end
                     end
                  endcase
               end
            end
            ST_GAP: begin
               // /CS stays high for the minimum deselect time and until no byte is parked
               if (gap_cnt_r != GAP_LAST) begin
                  gap_cnt_r <= gap_cnt_r + 1'b1;
               end else if (!pend_r) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign spi_cs_n      = cs_n_r;
   assign spi_out0      = out0_r;
   assign spi_oe0       = oe0_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_spi_rom_burst_reader.sv
// Self-checking bench: behavioural SPI flash, byte scoreboard, and a CLK_DIV=3 instance.
module tb_spi_rom_burst_reader;
   localparam int ADDR_W = 24;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_rom_burst_reader_if #(.ADDR_W(24), .LEN_W(10)) bus ();
   spi_rom_burst_reader_if #(.ADDR_W(24), .LEN_W(10)) bus3 ();

   logic       spi_cs_n, spi_sclk, spi_out0, spi_oe0;
   logic [3:0] spi_in = 4'h0;
   logic       cs3_n, sclk3, out03, oe03;
   logic [3:0] spi_in3 = 4'h0;

   spi_rom_burst_reader #(.ADDR_W(24), .LEN_W(10), .CLK_DIV(1), .DUMMY(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
      .spi_out0(spi_out0), .spi_oe0(spi_oe0), .spi_in(spi_in));

   spi_rom_burst_reader #(.ADDR_W(24), .LEN_W(10), .CLK_DIV(3), .DUMMY(8)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3), .spi_cs_n(cs3_n), .spi_sclk(sclk3),
      .spi_out0(out03), .spi_oe0(oe03), .spi_in(spi_in3));

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   int         done_cnt = 0;
   int         hs_cnt = 0;
   logic [7:0] exp_cmd = 8'h00;
   logic [23:0] exp_addr = 24'h0;
   logic [7:0] exp_b;

   // Flash contents: a fixed function of the address
   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every accepted byte is compared against the front of the expected queue
   always @(negedge clk) begin
      if (bus.done) done_cnt++;
      if (bus.out_valid && bus.out_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            check_eq("sb_unexpected_byte", 64'(exp_q.size()), 64'd1);
         end else begin
            exp_b = exp_q.pop_front();
            check_eq("sb_byte", 64'(bus.out_data), 64'(exp_b));
         end
      end
   end

   // Flash model, command side: capture io0 on SCLK rises, count oe0 levels per /CS frame
   int          rise_cnt = 0;
   int          oe_lo = 0, oe_hi = 0, oe_lo_last = 0, oe_hi_last = 0;
   logic [63:0] sh = 64'h0;
   always @(posedge spi_sclk or posedge spi_cs_n) begin
      if (spi_cs_n) begin
         oe_lo_last = oe_lo;
         oe_hi_last = oe_hi;
         oe_lo = 0;
         oe_hi = 0;
         rise_cnt = 0;
      end else begin
         if (spi_oe0) oe_hi++;
         else oe_lo++;
         if (rise_cnt < 8 + ADDR_W) begin
            sh = {sh[62:0], spi_out0};
            if (rise_cnt == 8 + ADDR_W - 1) begin
               check_eq("io0_cmd", 64'(sh[31:24]), 64'(exp_cmd));
               check_eq("io0_addr", 64'(sh[23:0]), 64'(exp_addr));
            end
         end
         rise_cnt++;
      end
   end

   // Flash model, data side: next bit/nibble presented after each SCLK fall
   int          k;
   logic [7:0]  fb;
   logic [23:0] fbase;
   logic        fquad;
   always @(negedge spi_sclk) begin
      if (!spi_cs_n) begin
         fbase = sh[23:0];
         fquad = (sh[31:24] == 8'h6B);
         if (!fquad && rise_cnt >= 32) begin
            k = rise_cnt - 32;
            fb = mem_byte(fbase + 24'(k / 8));
            spi_in <= {2'b00, fb[7 - (k % 8)], 1'b0};
         end else if (fquad && rise_cnt >= 40) begin
            k = rise_cnt - 40;
            fb = mem_byte(fbase + 24'(k / 2));
            spi_in <= ((k % 2) == 0) ? fb[7:4] : fb[3:0];
         end
      end
   end

   // CLK_DIV=3 instance: every SCLK phase after the first rise must last 3 clks
   int   ph_len = 0;
   logic ph_prev = 1'b0;
   logic ph_seen = 1'b0;
   always @(negedge clk) begin
      if (cs3_n) begin
         ph_seen = 1'b0;
         ph_len = 0;
         ph_prev = 1'b0;
      end else begin
         if (sclk3 != ph_prev) begin
            if (ph_seen) check_eq(ph_prev ? "div3_high_phase" : "div3_low_phase",
                                  64'(ph_len), 64'd3);
            ph_seen = 1'b1;
            ph_len = 1;
         end else begin
            ph_len++;
         end
         ph_prev = sclk3;
      end
   end

   task automatic push_exp(input logic [23:0] a, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(mem_byte(a + 24'(i)));
   endtask

   task automatic start_burst(input logic q, input logic [23:0] a, input logic [9:0] l);
      exp_cmd = q ? 8'h6B : 8'h03;
      exp_addr = a;
      @(posedge clk); #1;
      bus.quad = q; bus.addr = a; bus.len = l; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0;
      int i;
      d0 = done_cnt;
      i = 0;
      while (done_cnt == d0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      check_eq(tag, 64'(done_cnt != d0), 64'd1);
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int i;
      i = 0;
      while (!bus.out_valid && i < budget) begin
         @(negedge clk);
         i++;
      end
      check_eq(tag, 64'(bus.out_valid), 64'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, hs0, sclk_hi, vlow, chg, i;
      logic [7:0] held;
      bus.quad = 1'b0; bus.start = 1'b0; bus.addr = 24'h0; bus.len = 10'h0;
      bus.abort = 1'b0; bus.out_ready = 1'b1;
      bus3.quad = 1'b0; bus3.start = 1'b0; bus3.addr = 24'h0; bus3.len = 10'h0;
      bus3.abort = 1'b0; bus3.out_ready = 1'b1;
      held = 8'h00;

      // Reset values
      repeat (3) @(negedge clk);
      check_eq("rst_cs_n", 64'(spi_cs_n), 64'd1);
      check_eq("rst_sclk", 64'(spi_sclk), 64'd0);
      check_eq("rst_out0", 64'(spi_out0), 64'd0);
      check_eq("rst_oe0", 64'(spi_oe0), 64'd1);
      check_eq("rst_busy", 64'(bus.busy), 64'd0);
      check_eq("rst_done", 64'(bus.done), 64'd0);
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_out_data", 64'(bus.out_data), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // Single-line read, 4 bytes
      d0 = done_cnt;
      push_exp(24'h012345, 4);
      start_burst(1'b0, 24'h012345, 10'd3);
      @(negedge clk);
      check_eq("t1_busy_after_start", 64'(bus.busy), 64'd1);
      check_eq("t1_cs_low", 64'(spi_cs_n), 64'd0);
      wait_done("t1_done_seen", 500);
      repeat (20) @(negedge clk);
      check_eq("t1_done_once", 64'(done_cnt - d0), 64'd1);
      check_eq("t1_queue_empty", 64'(exp_q.size()), 64'd0);
      check_eq("t1_busy_end", 64'(bus.busy), 64'd0);
      check_eq("t1_oe0_high_rises", 64'(oe_hi_last), 64'd64);

      // Quad read, 1 byte: 8 dummy + 2 data rises with io0 released
      push_exp(24'hABCDE0, 1);
      start_burst(1'b1, 24'hABCDE0, 10'd0);
      wait_done("t2_done_seen", 500);
      repeat (5) @(negedge clk);
      check_eq("t2_oe0_low_rises", 64'(oe_lo_last), 64'd10);
      check_eq("t2_oe0_high_rises", 64'(oe_hi_last), 64'd32);
      check_eq("t2_queue_empty", 64'(exp_q.size()), 64'd0);

      // Consumer stall for 50 clks mid-burst
      push_exp(24'h000100, 6);
      start_burst(1'b0, 24'h000100, 10'd5);
      wait_valid("t3_first_valid", 400);
      @(posedge clk); #1 bus.out_ready = 1'b0;
      sclk_hi = 0; vlow = 0; chg = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (c == 20) held = bus.out_data;
         if (c >= 20 && !bus.out_valid) vlow++;
         if (c > 20 && bus.out_data != held) chg++;
         if (c >= 40 && spi_sclk) sclk_hi++;
      end
      check_eq("t3_sclk_parked_low", 64'(sclk_hi), 64'd0);
      check_eq("t3_valid_held", 64'(vlow), 64'd0);
      check_eq("t3_data_held", 64'(chg), 64'd0);
      @(posedge clk); #1 bus.out_ready = 1'b1;
      wait_done("t3_done_seen", 800);
      repeat (5) @(negedge clk);
      check_eq("t3_queue_empty", 64'(exp_q.size()), 64'd0);

      // Abort during the address phase
      d0 = done_cnt;
      hs0 = hs_cnt;
      start_burst(1'b0, 24'h0F0F0F, 10'd2);
      repeat (22) @(posedge clk);
      #1 bus.abort = 1'b1;
      @(posedge clk); #1 bus.abort = 1'b0;
      check_eq("t4_cs_n_next_clk", 64'(spi_cs_n), 64'd1);
      check_eq("t4_sclk_next_clk", 64'(spi_sclk), 64'd0);
      check_eq("t4_busy_in_gap", 64'(bus.busy), 64'd1);
      wait_done("t4_done_seen", 50);
      repeat (10) @(negedge clk);
      check_eq("t4_done_once", 64'(done_cnt - d0), 64'd1);
      check_eq("t4_no_bytes", 64'(hs_cnt - hs0), 64'd0);

      // start while busy is ignored
      d0 = done_cnt;
      push_exp(24'h123456, 2);
      start_burst(1'b0, 24'h123456, 10'd1);
      repeat (10) @(posedge clk);
      #1 bus.quad = 1'b1; bus.addr = 24'hFFFFFF; bus.len = 10'd7; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      wait_done("t5_done_seen", 500);
      repeat (20) @(negedge clk);
      check_eq("t5_done_once", 64'(done_cnt - d0), 64'd1);
      check_eq("t5_queue_empty", 64'(exp_q.size()), 64'd0);

      // Maximum length quad burst with address wrap
      push_exp(24'hFFFF00, 1024);
      start_burst(1'b1, 24'hFFFF00, 10'h3FF);
      wait_done("t6_done_seen", 6000);
      repeat (5) @(negedge clk);
      check_eq("t6_queue_empty", 64'(exp_q.size()), 64'd0);

      // Asynchronous reset in the data phase
      push_exp(24'h000040, 4);
      start_burst(1'b0, 24'h000040, 10'd3);
      wait_valid("t7_first_valid", 400);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      check_eq("t7_cs_n", 64'(spi_cs_n), 64'd1);
      check_eq("t7_sclk", 64'(spi_sclk), 64'd0);
      check_eq("t7_busy", 64'(bus.busy), 64'd0);
      check_eq("t7_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("t7_oe0", 64'(spi_oe0), 64'd1);
      exp_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // CLK_DIV=3 phase lengths on the second instance
      @(posedge clk); #1;
      bus3.quad = 1'b0; bus3.addr = 24'h000000; bus3.len = 10'd0; bus3.start = 1'b1;
      @(posedge clk); #1 bus3.start = 1'b0;
      i = 0;
      while (!bus3.done && i < 1000) begin
         @(negedge clk);
         i++;
      end
      check_eq("t8_div3_done_seen", 64'(bus3.done), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
